// File: rtl/gpr_cdb_arbiter_pkg.sv
// gpr_cdb_arbiter_pkg
//   Shared types and constants for the GPR common data bus.
//   ROB_WIDTH      : ROB tag width
//   N_GPR_CDB_REQ  : number of GPR-writing units arbitrating for the CDB
//   GPR_CDB_*      : fixed requester index of each unit (0 = highest fixed priority)
//   cdb_t          : {valid, tag, data} broadcast seen by RSs, ROB and GPR file
//   tag_match()    : consumer-side helper, true when a valid broadcast carries a tag
package gpr_cdb_arbiter_pkg;

    localparam int ROB_WIDTH     = 6;
    localparam int N_GPR_CDB_REQ = 4;

    localparam int GPR_CDB_MOV = 0;
    localparam int GPR_CDB_ALU = 1;
    localparam int GPR_CDB_LSU = 2;
    localparam int GPR_CDB_MUL = 3;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    function automatic logic tag_match(input cdb_t cdb, input logic [ROB_WIDTH-1:0] tag);
        return cdb.valid && (cdb.tag == tag);
    endfunction

endpackage

// File: rtl/gpr_cdb_arbiter_rr_pick.sv
// rr_pick
//   Pure combinational rotating picker: searches req starting at index ptr,
//   wrapping modulo N, and returns the first set bit. With ptr tied to 0 this
//   is a plain lowest-index-wins fixed-priority pick.
//   req    in  N   request vector
//   ptr    in  W   first index searched (must be < N)
//   onehot out N   one-hot grant, all zero when req is zero
//   idx    out W   index of the granted bit (0 when nothing granted)
//   any    out 1   at least one request present
module rr_pick
    import gpr_cdb_arbiter_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0] cand;
    logic       found;

    // Walk the N candidate positions ptr, ptr+1, ... (mod N); first requester wins.
    always_comb begin
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // ptr < N and i < N, so a single conditional subtract gives the modulo.
            cand = {1'b0, ptr} + (W+1)'(i);
            cand = (cand >= (W+1)'(N)) ? (cand - (W+1)'(N)) : cand;
            if (!found && req[cand[W-1:0]]) begin
                found = 1'b1;
                idx   = cand[W-1:0];
            end else begin
                found = found;
            end
        end
        any    = found;
        onehot = found ? (N'(1'b1) << idx) : '0;
    end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// gpr_cdb_arbiter
//   Sole driver of the GPR common data bus. Grants at most one requesting unit
//   per cycle (the unit dispatches on valid&&ready), then in the following cycle
//   broadcasts that unit's registered result with the captured ROB tag.
//   Latency req_valid -> gpr_cdb.valid is exactly one cycle; back-to-back grants
//   are allowed, so the bus can be valid every cycle.
//   clk         in   1                 clock
//   reset       in   1                 synchronous, active-high reset
//   req_valid   in   N_REQ             unit i has a dispatchable entry this cycle
//   req_ready   out  N_REQ             one-hot (or zero) grant, combinational
//   req_tag     in   N_REQ*ROB_WIDTH   ROB tag of unit i's candidate this cycle
//   req_result  in   N_REQ*32          unit i's result, valid the cycle after dispatch
//   gpr_cdb     out  cdb_t             {valid, tag, data} broadcast
//   grant_cnt   out  32                broadcasts since reset (CDB_STAT_EN), else 0
// Build options:
//   GPR_CDB_RR_EN  round-robin arbitration (default: fixed priority, index 0 highest)
//   CDB_STAT_EN    enables the free-running broadcast counter on grant_cnt
module gpr_cdb_arbiter
    import gpr_cdb_arbiter_pkg::*;
#(
    parameter  int N_REQ = N_GPR_CDB_REQ,
    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*ROB_WIDTH-1:0] req_tag,
    input  logic [N_REQ*32-1:0]        req_result,
    output cdb_t                       gpr_cdb,
    output logic [31:0]                grant_cnt
);

    logic [ROB_WIDTH-1:0] tag_arr    [N_REQ];
    logic [31:0]          result_arr [N_REQ];

    logic [SEL_W-1:0]     pick_ptr;
    logic [N_REQ-1:0]     pick_onehot;
    logic [SEL_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 grant;

    logic                 vld_r;
    logic [SEL_W-1:0]     sel_r;
    logic [ROB_WIDTH-1:0] tag_r;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign tag_arr[g]    = req_tag[g*ROB_WIDTH +: ROB_WIDTH];
        assign result_arr[g] = req_result[g*32 +: 32];
    end

`ifdef GPR_CDB_RR_EN
    logic [SEL_W-1:0] rr_ptr;

    // Rotate the search start to just past the last winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (pick_idx == SEL_W'(N_REQ-1)) ? '0 : (pick_idx + SEL_W'(1));
        end else begin
            rr_ptr <= rr_ptr;
        end
    end

    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = '0;
`endif

    rr_pick #(.N(N_REQ)) u_pick (
        .req    (req_valid),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign grant = pick_any && !reset;

    // Grant to the picked unit; nothing is granted while reset is asserted.
    always_comb begin
        if (reset) begin
            req_ready = '0;
        end else begin
            req_ready = pick_onehot;
        end
    end

    // Capture the winner; sel/tag hold across idle cycles since data is don't-care then.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= 1'b0;
            sel_r <= '0;
            tag_r <= '0;
        end else if (grant) begin
            vld_r <= 1'b1;
            sel_r <= pick_idx;
            tag_r <= tag_arr[pick_idx];
        end else begin
            vld_r <= 1'b0;
            sel_r <= sel_r;
            tag_r <= tag_r;
        end
    end

    // Broadcast: the unit registers its own result, so data is a plain mux on sel.
    // valid is masked by reset so a grant made just before reset is dropped.
    always_comb begin
        gpr_cdb.valid = vld_r && !reset;
        gpr_cdb.tag   = tag_r;
        gpr_cdb.data  = result_arr[sel_r];
    end

`ifdef CDB_STAT_EN
    logic [31:0] grant_cnt_r;

    // Count broadcasts actually seen on the bus; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_r <= 32'd0;
        end else if (vld_r) begin
            grant_cnt_r <= grant_cnt_r + 32'd1;
        end else begin
            grant_cnt_r <= grant_cnt_r;
        end
    end

    assign grant_cnt = grant_cnt_r;
`else
    assign grant_cnt = 32'd0;
`endif

endmodule
